// File: rtl/el2_lsu_dccm_rmw_ctl_if.sv
// el2_lsu_dccm_rmw_ctl_if: LSU request/response and DCCM lo-port bundle.
// master is the LSU/array side, slave is the sequencer.
interface el2_lsu_dccm_rmw_ctl_if #(
   parameter int DCCM_BITS        = 16,
   parameter int DCCM_FDATA_WIDTH = 39
);
   logic                        req_valid, req_ready, req_wr, req_err, rsp_valid;
   logic                        dccm_rden, dccm_wren;
   logic [DCCM_BITS-1:0]        req_addr, dccm_rd_addr_lo, dccm_wr_addr_lo;
   logic [1:0]                  req_size;
   logic [31:0]                 req_wdata, rsp_data;
   logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data_lo, dccm_wr_data_lo;
   modport master (
      output req_valid, req_wr, req_addr, req_size, req_wdata, dccm_rd_data_lo,
      input  req_ready, req_err, rsp_valid, rsp_data, dccm_rden, dccm_rd_addr_lo,
             dccm_wren, dccm_wr_addr_lo, dccm_wr_data_lo
   );
   modport slave (
      input  req_valid, req_wr, req_addr, req_size, req_wdata, dccm_rd_data_lo,
      output req_ready, req_err, rsp_valid, rsp_data, dccm_rden, dccm_rd_addr_lo,
             dccm_wren, dccm_wr_addr_lo, dccm_wr_data_lo
   );
endinterface

// File: rtl/el2_lsu_dccm_rmw_ctl.sv
// el2_lsu_dccm_rmw_ctl: DCCM sequencer; direct word access, read-modify-write for sub-word stores.
// All DCCM-side outputs are registered; rsp_data passes the array read data through.
module el2_lsu_dccm_rmw_ctl #(
   parameter int DCCM_BITS        = 16,
   parameter int DCCM_FDATA_WIDTH = 39
) (
   input logic                   clk,
   input logic                   rst_l,
   el2_lsu_dccm_rmw_ctl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RMW_RD, RMW_MRG} state_t;
   state_t                      r_state;
   logic                        r_rden, r_wren, r_rd_ld, r_rsp_valid, r_err;
   logic [DCCM_BITS-1:0]        r_rd_addr, r_wr_addr;
   logic [DCCM_FDATA_WIDTH-1:0] r_wr_data;
   logic [3:0]                  r_be;
   logic [31:0]                 r_lane_data;
   logic                        w_accept, w_bad;
   logic [DCCM_BITS-1:0]        w_waddr;
   logic [31:0]                 w_lane_mask, w_merged;

   function automatic logic [6:0] ecc_encode(input logic [31:0] d);
      logic [5:0] p;
      p = {^(d & 32'hFC00_0000), ^(d & 32'h03FF_F800), ^(d & 32'h03FC_07F0),
           ^(d & 32'hE3C3_C78E), ^(d & 32'h9B33_366D), ^(d & 32'h56AA_AD5B)};
      return {^{d, p}, p};
   endfunction

   assign bus.req_ready       = rst_l & (r_state == IDLE);
   assign w_accept            = bus.req_valid & bus.req_ready;
   assign w_bad               = (bus.req_size == 2'd3) | ((bus.req_size == 2'd1) & bus.req_addr[0]) |
                                ((bus.req_size == 2'd2) & |bus.req_addr[1:0]);
   assign w_waddr             = {bus.req_addr[DCCM_BITS-1:2], 2'b00};
   assign w_lane_mask         = {{8{r_be[3]}}, {8{r_be[2]}}, {8{r_be[1]}}, {8{r_be[0]}}};
   // old ECC is dropped: merge raw data and re-encode
   assign w_merged            = (bus.dccm_rd_data_lo[31:0] & ~w_lane_mask) | (r_lane_data & w_lane_mask);
   assign bus.req_err         = r_err;
   assign bus.rsp_valid       = r_rsp_valid;
   assign bus.rsp_data        = r_rsp_valid ? bus.dccm_rd_data_lo[31:0] : 32'h0;
   assign bus.dccm_rden       = r_rden;
   assign bus.dccm_rd_addr_lo = r_rd_addr;
   assign bus.dccm_wren       = r_wren;
   assign bus.dccm_wr_addr_lo = r_wr_addr;
   assign bus.dccm_wr_data_lo = r_wr_data;

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_state     <= IDLE;
         r_rden      <= 1'b0;
         r_wren      <= 1'b0;
         r_rd_ld     <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_err       <= 1'b0;
         r_rd_addr   <= '0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_be        <= '0;
         r_lane_data <= '0;
      end else begin
         r_rden      <= 1'b0;
         r_wren      <= 1'b0;
         r_err       <= 1'b0;
         r_rd_ld     <= 1'b0;
         r_rsp_valid <= r_rden & r_rd_ld;
         if (r_state == RMW_RD) begin
            r_state <= RMW_MRG;
         end else if (r_state == RMW_MRG) begin
            r_state   <= IDLE;
            r_wren    <= 1'b1;
            r_wr_addr <= r_rd_addr;
            r_wr_data <= {ecc_encode(w_merged), w_merged};
         end else if (w_accept) begin
            if (w_bad) begin
               r_err <= 1'b1;
            end else if (!bus.req_wr) begin
               r_rden    <= 1'b1;
               r_rd_ld   <= 1'b1;
               r_rd_addr <= w_waddr;
            end else if (bus.req_size == 2'd2) begin
               r_wren    <= 1'b1;
               r_wr_addr <= w_waddr;
               r_wr_data <= {ecc_encode(bus.req_wdata), bus.req_wdata};
            end else begin
               r_state     <= RMW_RD;
               r_rden      <= 1'b1;
               r_rd_addr   <= w_waddr;
               r_be        <= (bus.req_size[0] ? 4'b0011 : 4'b0001) << bus.req_addr[1:0];
               r_lane_data <= bus.req_size[0] ? {2{bus.req_wdata[15:0]}} : {4{bus.req_wdata[7:0]}};
            end
         end
      end
   end
endmodule

// File: doc/el2_lsu_dccm_rmw_ctl.md
# el2_lsu_dccm_rmw_ctl

DCCM access sequencer that sits directly upstream of the DCCM memory wrapper and drives its `_lo` read/write port. It accepts LSU word/half/byte load and store requests. Word stores and loads go straight to the array with ECC generated for stores. Sub-word stores run a read-modify-write: read the word, merge the new bytes, regenerate the 7-bit SECDED ECC, write back. All DCCM-side outputs are registered.

## Interface
- `DCCM_BITS`, 16: byte-address width of the DCCM.
- `DCCM_FDATA_WIDTH`, 39: stored word width, 32 data bits plus 7 ECC bits.
- `clk` in 1: core clock. One clock domain only.
- `rst_l` in 1: reset, asynchronous and active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid & req_ready`.
- `req_wr` in 1: 1 = store, 0 = load.
- `req_addr` in DCCM_BITS: byte address.
- `req_size` in 2: 0 = byte, 1 = half, 2 = word, 3 = illegal.
- `req_wdata` in 32: store data, right-justified (byte in [7:0], half in [15:0]).
- `req_err` out 1: one-cycle pulse, request rejected (misaligned or illegal size).
- `rsp_valid` out 1: load data valid, one-cycle pulse.
- `rsp_data` out 32: full loaded word, bits [31:0] of the array word; no ECC check here.
- `dccm_rden` out 1: DCCM read enable.
- `dccm_rd_addr_lo` out DCCM_BITS: read address.
- `dccm_rd_data_lo` in DCCM_FDATA_WIDTH: read data, valid the cycle after `dccm_rden`.
- `dccm_wren` out 1: DCCM write enable.
- `dccm_wr_addr_lo` out DCCM_BITS: write address.
- `dccm_wr_data_lo` out DCCM_FDATA_WIDTH: write data, {ecc[6:0], data[31:0]}.

## Operation
- **States:** IDLE, RMW_RD, RMW_MRG.
  - `req_ready` = (state == IDLE).
- **Address rule:** all DCCM addresses are word-aligned: `{req_addr[DCCM_BITS-1:2], 2'b00}`. The byte offset is `req_addr[1:0]`.
- **Rejection:** size 3, a half with addr[0]=1, or a word with addr[1:0]≠0 is rejected.
  - `req_err` is registered and pulses the cycle after acceptance.
  - No DCCM access occurs and the state is unchanged.
- **Load:** accepted in IDLE, state stays IDLE.
  - `dccm_rden` pulses the next cycle.
  - `rsp_valid` and `rsp_data` are driven the cycle after that.
- **Word store:** accepted in IDLE, state stays IDLE.
  - Next cycle: `dccm_wren`=1 with data = `req_wdata` and ECC = encode(`req_wdata`).
- **Sub-word store:** accepted in IDLE.
  - The address, offset, size and data are latched and state goes to RMW_RD.
  - RMW_RD: `dccm_rden`=1 (registered from the acceptance cycle); go to RMW_MRG.
  - RMW_MRG: capture `dccm_rd_data_lo[31:0]`, replace the addressed byte/half lanes with the latched data, compute ECC, and register the write. Return to IDLE.
  - `dccm_wren` is asserted in the first IDLE cycle after RMW_MRG.
- **Merge:** the old ECC bits are discarded; no correction is applied before the merge.
- **ECC encode:** bit-identical to the core's 7-bit SECDED encoder.
  - ecc[5:0] are Hamming parities over the 32 data bits.
  - ecc[6] = XOR of data[31:0] and ecc[5:0].
- **Back-to-back:** loads and word stores may be accepted every cycle (pipelined).
  - A load in flight when an RMW is accepted still returns its data on schedule.
  - The RMW read never collides with that load's read cycle.
- **Reset values:**
  - state = IDLE.
  - `req_ready`=1 once out of reset; 0 while `rst_l`=0.
  - `req_err`, `rsp_valid`, `dccm_rden`, `dccm_wren` = 0.
  - Addresses, `rsp_data` and `dccm_wr_data_lo` = 0.
- **Reset mid-operation:** asynchronous return to IDLE; all enables drop immediately. A partially sequenced RMW produces no write.

## Timing
- Load: accept at cycle N, `dccm_rden` at N+1, `rsp_valid` at N+2.
- Word store: accept at N, `dccm_wren` at N+1.
- Rejected request: accept at N, `req_err` at N+1.
- Sub-word store: accept at N.
  - `req_ready`=0 at N+1 and N+2.
  - `dccm_rden` at N+1, read data sampled at N+2, `dccm_wren` at N+3.
  - A new request can be accepted at N+3; its DCCM op lands at N+4.
- RMW issue rate: one per 3 cycles.
- Read-after-RMW to the same word is coherent because acceptance stalls until the write has registered.
- Never: `dccm_rden` and `dccm_wren` high in the same cycle for the same address from one RMW.

## Test plan
1. **Word store then load:** store word 0x0000_0000 to addr 0x0010 at N, load 0x0010 at N+1.
   - N+1: `dccm_wren`=1, addr 0x0010, wr_data = 39'h0 (ECC of zero is 0).
   - N+2: `dccm_rden`. N+3: `rsp_valid`, `rsp_data`=0.
2. **Byte store RMW:** model array word 0x1122_3344 at 0x0020; store byte 0xAB to 0x0022.
   - `req_ready` low for 2 cycles.
   - `dccm_wren` at N+3 with data 0x11AB_3344 and ECC = encoder(0x11AB_3344).
3. **Misaligned and illegal requests:** half store to 0x0021, then word load with size 3.
   - `req_err` pulses at N+1 and N+2.
   - No `dccm_rden`/`dccm_wren`; `req_ready` stays 1.
4. **Load in flight during RMW:** load 0x0030 at N, half store 0xBEEF to 0x0032 at N+1.
   - `rsp_valid` at N+2 with the 0x0030 data.
   - RMW `dccm_rden` at N+2, `dccm_wren` at N+4 with the upper half = 0xBEEF.
5. **Reset mid-RMW:** assert `rst_l`=0 in the RMW_MRG cycle.
   - All outputs go to reset values immediately and no `dccm_wren` occurs.
   - After release, `req_ready`=1 and a word store completes normally.
6. **Throughput:** 8 back-to-back word stores, then 8 loads, to consecutive word addresses.
   - One DCCM op per cycle.
   - Every load returns the matching stored data two cycles after acceptance.
